seq_accum_alu: RTL and testbench

- Parametrised successor to the current 16-bit accumulator ALU.
- Combines an opcode-driven datapath with a 2W-bit accumulator register; the accumulator's low W bits feed back as the second operand (FBK).
- Multiply, divide and modulo are multi-cycle sequential units (shift-add and restoring division), not combinational delay loops.
- A START/BUSY/DONE handshake connects the block to the bench or sequencer, replacing fixed-delay sampling.

---
 rtl/seq_accum_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_accum_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_accum_alu.sv
// seq_accum_alu: opcode-driven accumulator ALU with a 2W-bit accumulator.
// The low W bits of ACC feed back as operand B. ADD/SUB/logic-style ops
// complete at the accept edge; MUL (shift-add) and DIV/MOD (restoring
// division) take exactly W iteration edges behind a START/BUSY/DONE handshake.
module seq_accum_alu #(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     IN1,
    input  logic [3:0]       OP,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [2*W-1:0]   ACC,
    output logic [1:0]       ERR
);

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_CLR    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_MUL    = 4'b0100;
    localparam logic [3:0] OP_DIV    = 4'b0101;
    localparam logic [3:0] OP_MOD    = 4'b0110;
    localparam logic [3:0] OP_PRESET = 4'b1110;
    localparam logic [3:0] OP_RESET  = 4'b1111;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ITER = 1'b1;

    localparam logic [1:0] K_MUL = 2'd0;
    localparam logic [1:0] K_DIV = 2'd1;
    localparam logic [1:0] K_MOD = 2'd2;

    logic [0:0]     state;
    logic [CW-1:0]  cnt;
    logic [1:0]     kind_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;

    logic [W-1:0]   b_in;
    logic           accept;
    logic           multi;
    logic           last;
    logic [W:0]     sum;
    logic [2*W-1:0] diff;
    logic [2*W-1:0] prod_nxt;
    logic [2*W-1:0] dstep;

    // One shift-add step: add A shifted to the current bit position when
    // the multiplier's current LSB is set.
    function automatic logic [2*W-1:0] mul_step(
        input logic [2*W-1:0] p,
        input logic [W-1:0]   a,
        input logic           bit0,
        input logic [CW-1:0]  sh
    );
        logic [2*W-1:0] addend;
        addend = {{W{1'b0}}, a} << sh;
        return bit0 ? p + addend : p;
    endfunction

    // One restoring-division step; returns {remainder, quotient}.
    // The dividend is consumed MSB-first out of the quotient register.
    function automatic logic [2*W-1:0] div_step(
        input logic [W-1:0] r,
        input logic [W-1:0] q,
        input logic [W-1:0] d
    );
        logic [W:0] sh;
        logic       fits;
        sh   = {r, q[W-1]};
        fits = (sh >= {1'b0, d});
        if (fits) begin
            sh = sh - {1'b0, d};
        end
        return {sh[W-1:0], q[W-2:0], fits};
    endfunction

    assign BUSY     = (state == S_ITER);
    assign b_in     = ACC[W-1:0];
    assign accept   = START && !BUSY;
    assign multi    = (OP == OP_MUL) ||
                      (((OP == OP_DIV) || (OP == OP_MOD)) && (b_in != '0));
    assign last     = (cnt == CW'(W - 1));
    assign sum      = {1'b0, IN1} + {1'b0, b_in};
    assign diff     = {{W{1'b0}}, IN1} - {{W{1'b0}}, b_in};
    assign prod_nxt = mul_step(prod_q, a_q, b_q[0], cnt);
    assign dstep    = div_step(rem_q, quo_q, b_q);

    // Iteration datapath: load operands on accept, advance one step per busy edge.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_q    <= IN1;
            b_q    <= b_in;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= IN1;
            kind_q <= (OP == OP_MUL) ? K_MUL : ((OP == OP_DIV) ? K_DIV : K_MOD);
        end else if (BUSY) begin
            prod_q <= prod_nxt;
            rem_q  <= dstep[2*W-1:W];
            quo_q  <= dstep[W-1:0];
            if (kind_q == K_MUL) begin
                b_q <= b_q >> 1;
            end
        end
    end

    // Control FSM and architectural state: ACC/ERR written at accept for
    // single-cycle ops, or at the W-th iteration edge for sequential ops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            DONE  <= 1'b0;
            ACC   <= '0;
            ERR   <= 2'b00;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (multi) begin
                            state <= S_ITER;
                            cnt   <= '0;
                        end else begin
                            DONE <= 1'b1;
                            case (OP)
                                OP_NOP: ;
                                OP_ADD: begin
                                    ACC <= {{(W-1){1'b0}}, sum};
                                    ERR <= {1'b0, sum[W]};
                                end
                                OP_SUB: begin
                                    ACC <= diff;
                                    ERR <= {1'b0, (IN1 < b_in)};
                                end
                                OP_DIV, OP_MOD: begin
                                    ACC <= '0;
                                    ERR <= 2'b10;
                                end
                                OP_PRESET: begin
                                    ACC <= '1;
                                    ERR <= 2'b00;
                                end
                                OP_CLR, OP_RESET: begin
                                    ACC <= '0;
                                    ERR <= 2'b00;
                                end
                                default: begin
                                    ACC <= '0;
                                    ERR <= 2'b00;
                                end
                            endcase
                        end
                    end
                end
                S_ITER: begin
                    if (last) begin
                        state <= S_IDLE;
                        DONE  <= 1'b1;
                        ERR   <= 2'b00;
                        case (kind_q)
                            K_MUL:   ACC <= prod_nxt;
                            K_DIV:   ACC <= {{W{1'b0}}, dstep[W-1:0]};
                            default: ACC <= {{W{1'b0}}, dstep[2*W-1:W]};
                        endcase
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_accum_alu.sv
// Directed bench for seq_accum_alu at W=8, 16 and 32. All three instances
// share clock, reset and operand buses; sel routes START to one instance and
// muxes its outputs into the observed signals.
module tb_seq_accum_alu;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_CLR    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_MUL    = 4'b0100;
    localparam logic [3:0] OP_DIV    = 4'b0101;
    localparam logic [3:0] OP_MOD    = 4'b0110;
    localparam logic [3:0] OP_GND    = 4'b1010;
    localparam logic [3:0] OP_PRESET = 4'b1110;
    localparam logic [3:0] OP_RESET  = 4'b1111;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] in1;
    logic [3:0]  op;
    logic        start;
    int          sel;
    int          w;
    logic [63:0] ones_w, ones_2w;
    int          n_vec, n_err;

    always #5 CLK = ~CLK;

    logic st8, st16, st32;
    assign st8  = start && (sel == 0);
    assign st16 = start && (sel == 1);
    assign st32 = start && (sel == 2);

    logic        b8, d8, b16, d16, b32, d32;
    logic [15:0] acc8;
    logic [31:0] acc16;
    logic [63:0] acc32;
    logic [1:0]  e8, e16, e32;

    seq_accum_alu #(.W(8)) u8 (.CLK(CLK), .RST(RST), .IN1(in1[7:0]), .OP(op), .START(st8),
                               .BUSY(b8), .DONE(d8), .ACC(acc8), .ERR(e8));
    seq_accum_alu #(.W(16)) u16 (.CLK(CLK), .RST(RST), .IN1(in1[15:0]), .OP(op), .START(st16),
                                 .BUSY(b16), .DONE(d16), .ACC(acc16), .ERR(e16));
    seq_accum_alu #(.W(32)) u32 (.CLK(CLK), .RST(RST), .IN1(in1), .OP(op), .START(st32),
                                 .BUSY(b32), .DONE(d32), .ACC(acc32), .ERR(e32));

    logic [63:0] acc_obs;
    logic [1:0]  err_obs;
    logic        busy_obs, done_obs;

    always_comb begin
        acc_obs  = '0;
        err_obs  = '0;
        busy_obs = 1'b0;
        done_obs = 1'b0;
        case (sel)
            0: begin acc_obs = {48'b0, acc8};  err_obs = e8;  busy_obs = b8;  done_obs = d8;  end
            1: begin acc_obs = {32'b0, acc16}; err_obs = e16; busy_obs = b16; done_obs = d16; end
            default: begin acc_obs = acc32;    err_obs = e32; busy_obs = b32; done_obs = d32; end
        endcase
    end

    task automatic issue(input logic [3:0] o, input logic [63:0] v);
        @(negedge CLK);
        op = o; in1 = v[31:0]; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic load(input logic [63:0] v);
        issue(OP_CLR, 64'd0);
        issue(OP_ADD, v);
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit held);
        logic [63:0] acc0;
        acc0 = acc_obs; held = 1'b1; cyc = 0;
        while (cyc < budget) begin
            @(posedge CLK); #1;
            cyc++;
            if (done_obs === 1'b1) break;
            if (busy_obs !== 1'b1 || acc_obs !== acc0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK); RST = 1'b1; start = 1'b0; #1;
        n_vec++; if (acc_obs !== 64'd0) begin n_err++; $display("FAIL rst_acc w=%0d got %h expected 0", w, acc_obs); end
        n_vec++; if (err_obs !== 2'b00 || busy_obs !== 1'b0 || done_obs !== 1'b0) begin n_err++; $display("FAIL rst_ctl w=%0d got err=%b busy=%b done=%b expected 00/0/0", w, err_obs, busy_obs, done_obs); end
        @(negedge CLK); RST = 1'b0;
        load(64'd10);
        n_vec++; if (acc_obs !== 64'd10) begin n_err++; $display("FAIL preload w=%0d got %h expected a", w, acc_obs); end
        @(negedge CLK); #2; RST = 1'b1; #1;
        n_vec++; if (acc_obs !== 64'd0 || busy_obs !== 1'b0 || err_obs !== 2'b00) begin n_err++; $display("FAIL async_rst w=%0d got acc=%h busy=%b err=%b expected 0/0/00", w, acc_obs, busy_obs, err_obs); end
        #1; RST = 1'b0;
    endtask

    task automatic test_add();
        issue(OP_ADD, 64'd10);
        n_vec++; if (acc_obs !== 64'd10 || err_obs !== 2'b00) begin n_err++; $display("FAIL add10 w=%0d got acc=%h err=%b expected a/00", w, acc_obs, err_obs); end
        n_vec++; if (done_obs !== 1'b1 || busy_obs !== 1'b0) begin n_err++; $display("FAIL add_done w=%0d got done=%b busy=%b expected 1/0", w, done_obs, busy_obs); end
        @(posedge CLK); #1;
        n_vec++; if (done_obs !== 1'b0) begin n_err++; $display("FAIL add_done_pulse w=%0d got %b expected 0", w, done_obs); end
        issue(OP_ADD, ones_w);
        n_vec++; if (acc_obs !== ones_w + 64'd10 || err_obs !== 2'b01) begin n_err++; $display("FAIL add_carry w=%0d got acc=%h err=%b expected %h/01", w, acc_obs, err_obs, ones_w + 64'd10); end
    endtask

    task automatic test_mul();
        int cyc; bit held;
        load(64'd10);
        issue(OP_MUL, 64'd15);
        n_vec++; if (busy_obs !== 1'b1 || done_obs !== 1'b0 || acc_obs !== 64'd10) begin n_err++; $display("FAIL mul_start w=%0d got busy=%b done=%b acc=%h expected 1/0/a", w, busy_obs, done_obs, acc_obs); end
        repeat (3) begin @(posedge CLK); #1; end
        op = OP_ADD; in1 = 32'd99; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n_vec++; if (busy_obs !== 1'b1 || acc_obs !== 64'd10) begin n_err++; $display("FAIL mul_ignore w=%0d got busy=%b acc=%h expected 1/a", w, busy_obs, acc_obs); end
        wait_done(w + 4, cyc, held);
        n_vec++; if (cyc !== w - 4 || !held) begin n_err++; $display("FAIL mul_latency w=%0d got %0d remaining held=%0d expected %0d held=1", w, cyc, held, w - 4); end
        n_vec++; if (acc_obs !== 64'd150 || err_obs !== 2'b00 || busy_obs !== 1'b0) begin n_err++; $display("FAIL mul_result w=%0d got acc=%h err=%b busy=%b expected 96/00/0", w, acc_obs, err_obs, busy_obs); end
        @(posedge CLK); #1;
        n_vec++; if (done_obs !== 1'b0 || acc_obs !== 64'd150) begin n_err++; $display("FAIL mul_after w=%0d got done=%b acc=%h expected 0/96", w, done_obs, acc_obs); end
    endtask

    task automatic test_div();
        int cyc; bit held;
        load(64'd7);
        issue(OP_DIV, 64'd100);
        wait_done(w + 4, cyc, held);
        n_vec++; if (cyc !== w || !held) begin n_err++; $display("FAIL div_latency w=%0d got %0d cycles held=%0d expected %0d held=1", w, cyc, held, w); end
        n_vec++; if (acc_obs !== 64'd14 || err_obs !== 2'b00) begin n_err++; $display("FAIL div_result w=%0d got acc=%h err=%b expected e/00", w, acc_obs, err_obs); end
        load(64'd7);
        issue(OP_MOD, 64'd100);
        wait_done(w + 4, cyc, held);
        n_vec++; if (cyc !== w || acc_obs !== 64'd2 || err_obs !== 2'b00) begin n_err++; $display("FAIL mod_result w=%0d got acc=%h after %0d cycles expected 2 after %0d", w, acc_obs, cyc, w); end
        load(ones_w);
        issue(OP_MUL, ones_w);
        wait_done(w + 4, cyc, held);
        n_vec++; if (cyc !== w || acc_obs !== ones_w * ones_w || err_obs !== 2'b00) begin n_err++; $display("FAIL mul_max w=%0d got acc=%h after %0d cycles expected %h", w, acc_obs, cyc, ones_w * ones_w); end
    endtask

    task automatic test_divzero();
        issue(OP_CLR, 64'd0);
        issue(OP_DIV, 64'd5);
        n_vec++; if (acc_obs !== 64'd0 || err_obs !== 2'b10) begin n_err++; $display("FAIL div0 w=%0d got acc=%h err=%b expected 0/10", w, acc_obs, err_obs); end
        n_vec++; if (busy_obs !== 1'b0 || done_obs !== 1'b1) begin n_err++; $display("FAIL div0_hs w=%0d got busy=%b done=%b expected 0/1", w, busy_obs, done_obs); end
        @(posedge CLK); #1;
        n_vec++; if (busy_obs !== 1'b0 || done_obs !== 1'b0) begin n_err++; $display("FAIL div0_after w=%0d got busy=%b done=%b expected 0/0", w, busy_obs, done_obs); end
        load(64'd5);
        issue(OP_SUB, 64'd3);
        n_vec++; if (acc_obs !== ones_2w - 64'd1 || err_obs !== 2'b01) begin n_err++; $display("FAIL sub_borrow w=%0d got acc=%h err=%b expected %h/01", w, acc_obs, err_obs, ones_2w - 64'd1); end
    endtask

    task automatic test_mul_abort();
        bit seen;
        load(64'd10);
        issue(OP_MUL, 64'd15);
        repeat (7) begin @(posedge CLK); #1; end
        n_vec++; if (busy_obs !== 1'b1) begin n_err++; $display("FAIL abort_busy w=%0d got %b expected 1", w, busy_obs); end
        @(negedge CLK); #1; RST = 1'b1; #1;
        n_vec++; if (acc_obs !== 64'd0 || busy_obs !== 1'b0 || done_obs !== 1'b0 || err_obs !== 2'b00) begin n_err++; $display("FAIL abort_rst w=%0d got acc=%h busy=%b done=%b err=%b expected 0/0/0/00", w, acc_obs, busy_obs, done_obs, err_obs); end
        #1; RST = 1'b0;
        seen = 1'b0;
        repeat (w + 2) begin @(posedge CLK); #1; if (done_obs === 1'b1 || busy_obs === 1'b1) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_quiet w=%0d got activity=%b expected 0", w, seen); end
        issue(OP_ADD, 64'd4);
        n_vec++; if (acc_obs !== 64'd4 || err_obs !== 2'b00) begin n_err++; $display("FAIL abort_add w=%0d got acc=%h err=%b expected 4/00", w, acc_obs, err_obs); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [9];
        logic [63:0] vals [9];
        logic [63:0] exps [9];
        logic [1:0]  errs [9];
        ops = '{OP_CLR, OP_ADD, OP_ADD, OP_SUB, OP_NOP, OP_PRESET, OP_GND, OP_PRESET, OP_RESET};
        vals = '{64'd0, 64'd3, 64'd4, 64'd2, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        exps = '{64'd0, 64'd3, 64'd7, ones_2w - 64'd4, ones_2w - 64'd4, ones_2w, 64'd0, ones_2w, 64'd0};
        errs = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        @(negedge CLK);
        for (int i = 0; i < 9; i++) begin
            op = ops[i]; in1 = vals[i][31:0]; start = 1'b1;
            @(posedge CLK); #1;
            n_vec++; if (acc_obs !== exps[i] || err_obs !== errs[i]) begin n_err++; $display("FAIL b2b[%0d] w=%0d got acc=%h err=%b expected %h/%b", i, w, acc_obs, err_obs, exps[i], errs[i]); end
            n_vec++; if (done_obs !== 1'b1 || busy_obs !== 1'b0) begin n_err++; $display("FAIL b2b_hs[%0d] w=%0d got done=%b busy=%b expected 1/0", i, w, done_obs, busy_obs); end
        end
        start = 1'b0;
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; op = 4'd0; in1 = 32'd0; sel = 0;
        n_vec = 0; n_err = 0;
        for (int s = 0; s < 3; s++) begin
            sel     = s;
            w       = (s == 0) ? 8 : ((s == 1) ? 16 : 32);
            ones_w  = (64'd1 << w) - 64'd1;
            ones_2w = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
            test_reset();
            test_add();
            test_mul();
            test_div();
            test_divzero();
            test_mul_abort();
            test_back_to_back();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
